muldiv_unit: RTL



---
 rtl/muldiv_unit_pkg.sv | 47 ++++
 rtl/muldiv_negate.sv | 13 +
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 op codes,
// FSM state encoding and small op-decode helpers.
package muldiv_defs;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic f3_is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

    function automatic logic f3_is_signed_div(input logic [2:0] f3);
        return (f3 == F3_DIV) | (f3 == F3_REM);
    endfunction

    function automatic logic f3_rs1_signed(input logic [2:0] f3);
        return (f3 != F3_MULHU) & (f3 != F3_DIVU) & (f3 != F3_REMU);
    endfunction

    function automatic logic f3_rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) | (f3 == F3_MULH) | (f3 == F3_DIV) | (f3 == F3_REM);
    endfunction

    function automatic logic f3_low_word(input logic [2:0] f3);
        return (f3 == F3_MUL) | f3[2];
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Combinational conditional two's-complement negate, used for operand
// magnitude extraction and for final sign correction.
module muldiv_negate #(
    parameter int W = 64
) (
    input  logic         neg_i,
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);

    assign y_o = neg_i ? (~a_i + {{(W-1){1'b0}}, 1'b1}) : a_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on magnitudes, one bit per clock, one-cycle write-back strobe.
module muldiv_unit
    import muldiv_defs::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            wren,
    output logic [4:0]      wr,
    output logic [XLEN-1:0] wd
);

    localparam int               DW       = 2 * XLEN;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [4:0]       wr_q, wr_d;
    logic [XLEN-1:0]  wd_q, wd_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic             neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             wren_q, wren_d;

    logic             a_neg_s, b_neg_s;
    logic [XLEN-1:0]  a_mag_s, b_mag_s;
    logic             div0_s, ovf_s, special_s;
    logic [XLEN-1:0]  special_res_s;
    logic [XLEN:0]    mul_sum_s;
    logic [DW-1:0]    mul_next_s;
    logic [XLEN:0]    rem_sh_s, trial_s;
    logic [DW-1:0]    div_next_s;
    logic [DW-1:0]    fix_in_s, fix_out_s;
    logic [XLEN-1:0]  fix_res_s;

    assign a_neg_s = f3_rs1_signed(funct3) & rs1_data[XLEN-1];
    assign b_neg_s = f3_rs2_signed(funct3) & rs2_data[XLEN-1];

    muldiv_negate #(.W(XLEN)) u_neg_a (.neg_i(a_neg_s), .a_i(rs1_data), .y_o(a_mag_s));
    muldiv_negate #(.W(XLEN)) u_neg_b (.neg_i(b_neg_s), .a_i(rs2_data), .y_o(b_mag_s));

    // Divides that bypass the iteration: divide-by-zero and INT_MIN / -1.
    assign div0_s    = f3_is_div(funct3) & (rs2_data == ZERO);
    assign ovf_s     = f3_is_signed_div(funct3) & (rs1_data == INT_MIN) & (rs2_data == ALL_ONES);
    assign special_s = div0_s | ovf_s;

    // Architectural result for the bypassed divide cases.
    always_comb begin
        special_res_s = ZERO;
        if (div0_s) begin
            special_res_s = f3_is_rem(funct3) ? rs1_data : ALL_ONES;
        end else begin
            special_res_s = f3_is_rem(funct3) ? ZERO : INT_MIN;
        end
    end

    // Multiply step: acc holds {partial high, remaining multiplier bits}.
    assign mul_sum_s  = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    assign mul_next_s = {mul_sum_s, acc_q[XLEN-1:1]};

    // Divide step: acc holds {partial remainder, dividend/quotient bits}.
    assign rem_sh_s = acc_q[DW-1:XLEN-1];
    assign trial_s  = rem_sh_s - {1'b0, mcand_q};

    // Restore on a negative trial difference, otherwise commit it and set a quotient bit.
    always_comb begin
        div_next_s = acc_q;
        if (trial_s[XLEN]) begin
            div_next_s = {rem_sh_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            div_next_s = {trial_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    // Select what the FIX stage sign-corrects: full product, quotient or remainder.
    always_comb begin
        fix_in_s = acc_q;
        if (f3_is_rem(op_q)) begin
            fix_in_s = {ZERO, acc_q[DW-1:XLEN]};
        end else if (f3_is_div(op_q)) begin
            fix_in_s = {ZERO, acc_q[XLEN-1:0]};
        end else begin
            fix_in_s = acc_q;
        end
    end

    muldiv_negate #(.W(DW)) u_neg_fix (.neg_i(neg_q), .a_i(fix_in_s), .y_o(fix_out_s));

    assign fix_res_s = f3_low_word(op_q) ? fix_out_s[XLEN-1:0] : fix_out_s[DW-1:XLEN];

    // Control FSM next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wr_d    = wr_q;
        wd_d    = wd_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        wren_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = funct3;
                    wr_d    = rd_in;
                    acc_d   = {ZERO, a_mag_s};
                    mcand_d = b_mag_s;
                    neg_d   = f3_is_rem(funct3) ? a_neg_s : (a_neg_s ^ b_neg_s);
                    cnt_d   = {CNT_W{1'b0}};
                    if (special_s) begin
                        wd_d    = special_res_s;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                acc_d = f3_is_div(op_q) ? div_next_s : mul_next_s;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_FIX: begin
                wd_d    = fix_res_s;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        wren_d = (state_d == ST_DONE);
    end

    // State and datapath registers; reset clears everything, aborting any op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= 3'b000;
            wr_q    <= 5'd0;
            wd_q    <= {XLEN{1'b0}};
            acc_q   <= {DW{1'b0}};
            mcand_q <= {XLEN{1'b0}};
            neg_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            wren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wr_q    <= wr_d;
            wd_q    <= wd_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            wren_q  <= wren_d;
        end
    end

    assign busy = busy_q;
    assign wren = wren_q;
    assign wr   = wr_q;
    assign wd   = wd_q;

endmodule
